// File: rtl/maq_display.sv
// maq_display: six-digit multiplexed 7-segment scanner with
// frame-synchronous shadowing, pair blinking and hours-tens blanking.
module maq_display #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 64,
  parameter bit LZB          = 1'b1
) (
  input  logic       maqd_clock,
  input  logic       maqd_reset,
  input  logic       maqd_enable,
  input  logic [3:0] maqd_s_lsd,
  input  logic [2:0] maqd_s_msd,
  input  logic [3:0] maqd_m_lsd,
  input  logic [2:0] maqd_m_msd,
  input  logic [3:0] maqd_h_lsd,
  input  logic [1:0] maqd_h_msd,
  input  logic [2:0] maqd_blink,
  output logic [5:0] maqd_an,
  output logic [6:0] maqd_seg,
  output logic       maqd_dp,
  output logic       maqd_frame
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);
  localparam logic [FW-1:0] F_LAST  = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]      presc_q, presc_d;
  logic [2:0]         idx_q, idx_d;
  logic [FW-1:0]      frm_q, frm_d;
  logic               phase_q, phase_d;
  logic [5:0][3:0]    sh_q, sh_d;
  logic [5:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic               frame_q, frame_d;

  logic               slot_end;
  logic               wrap;
  logic               blink_hit;
  logic               dark;
  logic [3:0]         digit;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  always_comb begin
    presc_d   = presc_q;
    idx_d     = idx_q;
    frm_d     = frm_q;
    phase_d   = phase_q;
    sh_d      = sh_q;
    an_d      = 6'h3F;
    seg_d     = 7'h7F;
    dp_d      = 1'b1;
    frame_d   = 1'b0;
    slot_end  = (presc_q == P_LAST);
    wrap      = slot_end && (idx_q == 3'd5);
    digit     = sh_q[idx_q];
    blink_hit = 1'b0;
    case (idx_q)
      3'd0, 3'd1: blink_hit = maqd_blink[0];
      3'd2, 3'd3: blink_hit = maqd_blink[1];
      3'd4, 3'd5: blink_hit = maqd_blink[2];
      default:    blink_hit = 1'b0;
    endcase
    dark = (presc_q < P_BLANK)
        || (phase_q && blink_hit)
        || (LZB && (idx_q == 3'd5) && (sh_q[5] == 4'd0));

    if (maqd_enable) begin
      presc_d = slot_end ? '0 : presc_q + PW'(1);
      if (slot_end) begin
        idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end
      // Capture only at frame boundary so a frame never tears.
      if (wrap) begin
        frame_d = 1'b1;
        sh_d = {{2'b00, maqd_h_msd}, maqd_h_lsd,
                {1'b0, maqd_m_msd}, maqd_m_lsd,
                {1'b0, maqd_s_msd}, maqd_s_lsd};
        if (frm_q == F_LAST) begin
          frm_d   = '0;
          phase_d = ~phase_q;
        end else begin
          frm_d = frm_q + FW'(1);
        end
      end
      if (!dark) begin
        an_d  = ~(6'd1 << idx_q);
        seg_d = decode(digit);
        dp_d  = !((idx_q == 3'd2) || (idx_q == 3'd4));
      end
    end
  end

  always_ff @(posedge maqd_clock or negedge maqd_reset) begin
    if (!maqd_reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      phase_q <= 1'b0;
      sh_q    <= '0;
      an_q    <= 6'h3F;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      phase_q <= phase_d;
      sh_q    <= sh_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign maqd_an    = an_q;
  assign maqd_seg   = seg_q;
  assign maqd_dp    = dp_q;
  assign maqd_frame = frame_q;

endmodule

// File: tb/tb_maq_display.sv
// tb_maq_display: scoreboard bench for the multiplexed display,
// expected output per cycle derived from the cycle number since reset.
module tb_maq_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] s_lsd, m_lsd, h_lsd;
  logic [2:0] s_msd, m_msd;
  logic [1:0] h_msd;
  logic [2:0] blink;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int frames_seen = 0;
  logic [3:0] shown [6];
  logic [14:0] sb [$];

  localparam logic [14:0] DARK = {6'h3F, 7'h7F, 1'b1, 1'b0};

  maq_display #(
    .SCAN_DIV(4), .BLANK_CYC(1), .BLINK_FRAMES(2), .LZB(1'b1)
  ) dut (
    .maqd_clock(clk), .maqd_reset(rst_n), .maqd_enable(en),
    .maqd_s_lsd(s_lsd), .maqd_s_msd(s_msd),
    .maqd_m_lsd(m_lsd), .maqd_m_msd(m_msd),
    .maqd_h_lsd(h_lsd), .maqd_h_msd(h_msd),
    .maqd_blink(blink),
    .maqd_an(an), .maqd_seg(seg), .maqd_dp(dp), .maqd_frame(frame)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Outputs after edge c show the state that held during cycle c.
  function automatic logic [14:0] model(input int c);
    int slot, p, f;
    logic ph, fr, dk;
    logic [5:0] a;
    slot = (c / 4) % 6;
    p    = c % 4;
    f    = c / 24;
    ph   = ((f / 2) % 2) == 1;
    fr   = (c % 24) == 23;
    dk   = (p < 1) || (ph && blink[slot / 2])
        || (slot == 5 && shown[5] == 4'd0);
    if (dk) return {6'h3F, 7'h7F, 1'b1, fr};
    a = 6'h3F;
    a[slot] = 1'b0;
    return {a, seg_of(shown[slot]), !(slot == 2 || slot == 4), fr};
  endfunction

  task automatic set_time(input logic [7:0] h, input logic [7:0] m,
                          input logic [7:0] s);
    h_msd = h[5:4]; h_lsd = h[3:0];
    m_msd = m[6:4]; m_lsd = m[3:0];
    s_msd = s[6:4]; s_lsd = s[3:0];
  endtask

  task automatic step(input string tag);
    logic [14:0] e, got;
    logic [3:0] cap [6];
    logic wrap;
    cap = '{s_lsd, {1'b0, s_msd}, m_lsd, {1'b0, m_msd},
            h_lsd, {2'b00, h_msd}};
    wrap = en && ((cyc % 24) == 23);
    e = en ? model(cyc) : DARK;
    sb.push_back(e);
    @(posedge clk); #1;
    got = {an, seg, dp, frame};
    e = sb.pop_front();
    total++;
    if (got !== e)
      $display("FAIL %s cyc=%0d an/seg/dp/frame got=%b_%b_%b_%b exp=%b_%b_%b_%b",
               tag, cyc, got[14:9], got[8:2], got[1], got[0],
               e[14:9], e[8:2], e[1], e[0]);
    else passed++;
    if (frame) frames_seen++;
    if (wrap) shown = cap;
    if (en) cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    foreach (shown[i]) shown[i] = 4'd0;
  endtask

  task automatic test_reset();
    en = 1'b1; blink = 3'b000;
    set_time(8'h12, 8'h34, 8'h56);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({an, seg, dp, frame} !== DARK)
      $display("FAIL reset_state got=%h exp=%h", {an, seg, dp, frame}, DARK);
    else passed++;
    do_reset();
  endtask

  task automatic test_scan();
    frames_seen = 0;
    repeat (48) step("scan");
    total++;
    if (frames_seen !== 2)
      $display("FAIL frame_count got=%0d exp=2", frames_seen);
    else passed++;
  endtask

  task automatic test_lzb();
    set_time(8'h05, 8'h34, 8'h56);
    while ((cyc % 24) != 0) step("lzb_wait");
    repeat (24) step("lzb");
  endtask

  task automatic test_tear();
    set_time(8'h12, 8'h34, 8'h56);
    while ((cyc % 24) != 0) step("tear_sync");
    repeat (24) step("tear_pre");
    while ((cyc % 24) != 9) step("tear_to_slot2");
    set_time(8'h23, 8'h59, 8'h59);
    while ((cyc % 24) != 0) step("tear_old");
    repeat (24) step("tear_new");
  endtask

  task automatic test_enable();
    s_lsd = 4'hA;
    while ((cyc % 24) != 0) step("en_sync");
    while ((cyc % 24) != 13) step("en_to_slot3");
    en = 1'b0;
    repeat (10) step("en_low");
    en = 1'b1;
    while ((cyc % 24) != 0) step("en_resume");
    repeat (24) step("en_next");
  endtask

  task automatic test_reset_mid();
    set_time(8'h12, 8'h34, 8'h56);
    while ((cyc % 24) != 18) step("mid_to_slot4");
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({an, seg, dp, frame} !== DARK)
      $display("FAIL async_reset got=%h exp=%h", {an, seg, dp, frame}, DARK);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    foreach (shown[i]) shown[i] = 4'd0;
    step("post_reset");
    step("post_reset");
    total++;
    if (an !== 6'b111110 || seg !== 7'b1000000)
      $display("FAIL first_lit got=%b/%b exp=111110/1000000", an, seg);
    else passed++;
    repeat (22) step("post_reset");
  endtask

  task automatic test_blink();
    do_reset();
    blink = 3'b010;
    repeat (8 * 24) step("blink");
    blink = 3'b000;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lzb();
    test_tear();
    test_enable();
    test_reset_mid();
    test_blink();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/maq_display.md
# maq_display

Multiplexed six-digit 7-segment driver for the clock. Reads the BCD digit pairs produced by the seconds, minutes and hours counters, snapshots them once per frame, and scans them one digit at a time onto a common-anode display. It supports per-pair blinking for time-set mode and leading-zero blanking of the hours tens digit. It sits between the counter chain and the board pins.

## Interface
Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot (≥ 2).
- BLANK_CYC, 16: anti-ghosting cycles at the start of each slot with every anode off (< SCAN_DIV).
- BLINK_FRAMES, 64: frames per blink half-period (≥ 1).
- LZB, 1: when 1, the hours tens digit is blanked if it is zero.

Ports:
- maqd_clock, in, 1: clock.
- maqd_reset, in, 1: reset, asynchronous, active-low.
- maqd_enable, in, 1: scan enable. When low, counters hold and the display is dark.
- maqd_s_lsd, in, 4: seconds units.
- maqd_s_msd, in, 3: seconds tens.
- maqd_m_lsd, in, 4: minutes units.
- maqd_m_msd, in, 3: minutes tens.
- maqd_h_lsd, in, 4: hours units.
- maqd_h_msd, in, 2: hours tens.
- maqd_blink, in, 3: per-pair blink request. bit0 = seconds, bit1 = minutes, bit2 = hours.
- maqd_an, out, 6: anodes, active-low, one-hot when lit. Bit k = slot k.
- maqd_seg, out, 7: segments {g,f,e,d,c,b,a}, active-low.
- maqd_dp, out, 1: decimal point, active-low.
- maqd_frame, out, 1: one-cycle pulse at the end of each frame.

## Operation
- Slot order (index 0..5): s_lsd, s_msd, m_lsd, m_msd, h_lsd, h_msd.
- Prescaler counts 0..SCAN_DIV-1. At its terminal count:
  - the index advances;
  - index 5 wraps to 0.
- Shadow registers capture all six digit inputs, zero-extended to 4 bits, on the wrap edge 5→0. Inputs are ignored at every other time, so the display never tears mid-frame.
- Frame counter counts wraps 0..BLINK_FRAMES-1. At its terminal count it toggles blink_phase.
- Digit decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 = dash 0111111
- A slot is dark when any of these holds:
  - the prescaler is < BLANK_CYC;
  - blink_phase=1 and the blink bit for the slot's pair is set;
  - LZB=1, slot 5, and the shadow h_msd is 0.
- In a dark slot: an=111111 and seg=1111111.
- Otherwise: an[k]=0 for the current slot only, and seg = decode(shadow digit).
- dp=0 only in lit slots 2 and 4 (the hh.mm.ss separators). Otherwise dp=1.
- maqd_frame=1 for exactly the cycle in which the 5→0 wrap occurs.
- maqd_enable=0:
  - prescaler, index, frame counter, blink_phase and shadows hold;
  - an=111111, seg=1111111, dp=1, frame=0.
- On re-enable, scanning resumes from the held prescaler value.
- Reset values, applied immediately on reset assertion without waiting for a clock edge:
  - an=111111, seg=1111111, dp=1, frame=0;
  - index=0, prescaler=0, frame counter=0, blink_phase=0;
  - shadows=0.

## Timing
- All outputs are registered and update on the same edge as the prescaler and index.
- Slot length is exactly SCAN_DIV cycles. Frame length is 6·SCAN_DIV cycles.
- Within slot k:
  - cycles 0..BLANK_CYC-1: dark;
  - cycles BLANK_CYC..SCAN_DIV-1: an[k]=0, provided no other dark condition holds.
- New input values appear in slot 0 of the frame that starts on the capture edge. Worst-case input-to-display latency is 6·SCAN_DIV + BLANK_CYC cycles.
- After reset release:
  - slot 0 prescaler cycle 0 is the first enabled edge;
  - the first frame shows the zero shadows (displays 0 0.0 0.0 0 with h_msd blank when LZB=1).
- Blink half-period is BLINK_FRAMES·6·SCAN_DIV cycles. A blink request change takes effect at the next slot evaluated.
- Reset asserted mid-slot:
  - outputs go to reset values asynchronously;
  - the pending capture and frame pulse are lost.

## Test plan
Bench parameters: SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2, LZB=1.
- Inputs 12:34:56, blink=000, run two frames. Second frame, per slot:
  - slot0: an=111110, seg=0000010;
  - slot1: seg=0010010;
  - slot2: seg=0011001, dp=0;
  - slot3: seg=0110000;
  - slot4: seg=0100100, dp=0;
  - slot5: an=011111, seg=1111001.
  - Each slot's prescaler cycle 0 is dark, and frame pulses once per 24 cycles.
- Hours 05 → slot5 stays an=111111 and seg=1111111 for the whole slot.
- Change the inputs from 12:34:56 to 23:59:59 during slot 2 → the rest of that frame still shows 12:34:56. The next frame shows 23:59:59.
- blink=010 → slots 2 and 3 are dark in frames 2,3 and 6,7, and lit in frames 4,5. Slots 0,1,4,5 are unaffected.
- s_lsd=4'hA → slot0 seg=0111111. Drop enable for 10 cycles in slot 3:
  - an=111111 and frame=0 while enable is low;
  - after re-enable, slot 3 resumes with the remaining cycle count unchanged.
- Assert reset in slot 4 between clock edges → outputs go to reset values immediately. After release, the first lit slot is slot 0 showing 0, with seg=1000000.
